// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequencing front end for the 256-word RAM/FLASH array.
// Turns valid/ready single or burst requests (up to 2^LEN_W beats) into raw
// ADDR/IN/WR strobes, holding each read beat in a response register until
// the consumer takes it. Burst addresses increment and wrap at 2^ADDR_W.

`ifndef DATA_BUS_LEN
`define DATA_BUS_LEN 32
`endif

module mem_access_ctrl #(
  parameter int DATA_W = `DATA_BUS_LEN,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WR,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [LEN_W-1:0]  REQ_LEN,
  input  logic              WDATA_VALID,
  input  logic [DATA_W-1:0] WDATA,
  output logic              WDATA_READY,
  output logic              RDATA_VALID,
  output logic [DATA_W-1:0] RDATA,
  input  logic              RDATA_READY,
  output logic              DONE,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_IN,
  output logic              MEM_WR,
  input  logic [DATA_W-1:0] MEM_OUT
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] RHOLD = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remain;
  logic              in_write;

  assign in_write    = (state == WRITE);
  assign REQ_READY   = (state == IDLE);
  assign WDATA_READY = in_write;
  assign MEM_ADDR    = {{(DATA_W-ADDR_W){1'b0}}, cur_addr};
  assign MEM_IN      = in_write ? WDATA : '0;
  // The write strobe is combinational so the array stores on the same edge
  // the beat is accepted; reset masks it so an aborted burst writes nothing.
  assign MEM_WR      = in_write && WDATA_VALID && !RST;

  // Burst sequencer: address/length bookkeeping, read capture and DONE pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remain      <= '0;
      RDATA       <= '0;
      RDATA_VALID <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            cur_addr <= REQ_ADDR;
            remain   <= REQ_LEN;
            state    <= REQ_WR ? WRITE : READ;
          end
        end
        READ: begin
          RDATA       <= MEM_OUT;
          RDATA_VALID <= 1'b1;
          state       <= RHOLD;
        end
        RHOLD: begin
          if (RDATA_READY) begin
            RDATA_VALID <= 1'b0;
            if (remain == '0) begin
              state <= IDLE;
              DONE  <= 1'b1;
            end else begin
              cur_addr <= cur_addr + ADDR_ONE;
              remain   <= remain - LEN_ONE;
              state    <= READ;
            end
          end
        end
        WRITE: begin
          if (WDATA_VALID) begin
            if (remain == '0) begin
              state <= IDLE;
              DONE  <= 1'b1;
            end else begin
              cur_addr <= cur_addr + ADDR_ONE;
              remain   <= remain - LEN_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a behavioural 256-word array
// attached to the raw memory port.

module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WR;
  logic [7:0]  REQ_ADDR;
  logic [2:0]  REQ_LEN;
  logic        WDATA_VALID;
  logic [31:0] WDATA;
  logic        WDATA_READY;
  logic        RDATA_VALID;
  logic [31:0] RDATA;
  logic        RDATA_READY;
  logic        DONE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_IN;
  logic        MEM_WR;
  logic [31:0] MEM_OUT;

  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  int          wr_count = 0;
  int          errors = 0;
  int          checks = 0;

  mem_access_ctrl dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .WDATA_VALID(WDATA_VALID), .WDATA(WDATA), .WDATA_READY(WDATA_READY),
    .RDATA_VALID(RDATA_VALID), .RDATA(RDATA), .RDATA_READY(RDATA_READY),
    .DONE(DONE), .MEM_ADDR(MEM_ADDR), .MEM_IN(MEM_IN), .MEM_WR(MEM_WR),
    .MEM_OUT(MEM_OUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural array: combinational read, write on the clock edge.
  assign MEM_OUT = mem[MEM_ADDR[7:0]];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + i;
    end else if (MEM_WR) begin
      mem[MEM_ADDR[7:0]] <= MEM_IN;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_req(input logic wr, input logic [7:0] addr, input logic [2:0] len);
    REQ_VALID = 1'b1;
    REQ_WR    = wr;
    REQ_ADDR  = addr;
    REQ_LEN   = len;
    tick();
    REQ_VALID = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 8'h33; REQ_LEN = 3'd1;
    WDATA_VALID = 1'b1; WDATA = 32'h1234_5678; RDATA_READY = 1'b0; mem_init = 1'b1;
    #1;
    checks++; if (MEM_WR !== 1'b0) begin errors++; $display("[TB] FAIL rst_memwr0 got=%b exp=0", MEM_WR); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (MEM_WR !== 1'b0) begin errors++; $display("[TB] FAIL rst_memwr got=%b exp=0", MEM_WR); end
      checks++; if (REQ_READY !== 1'b1) begin errors++; $display("[TB] FAIL rst_reqready got=%b exp=1", REQ_READY); end
      checks++; if (WDATA_READY !== 1'b0) begin errors++; $display("[TB] FAIL rst_wready got=%b exp=0", WDATA_READY); end
    end
    mem_init = 1'b0; RST = 1'b0; REQ_VALID = 1'b0; WDATA_VALID = 1'b0;
    #1;
    checks++; if ({RDATA_VALID, DONE, MEM_WR, WDATA_READY} !== 4'b0) begin errors++; $display("[TB] FAIL rst_flags got=%b exp=0000", {RDATA_VALID, DONE, MEM_WR, WDATA_READY}); end
    checks++; if (RDATA !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata got=%h exp=0", RDATA); end
    checks++; if (MEM_ADDR !== 32'h0) begin errors++; $display("[TB] FAIL rst_memaddr got=%h exp=0", MEM_ADDR); end
    checks++; if (MEM_IN !== 32'h0) begin errors++; $display("[TB] FAIL rst_memin got=%h exp=0", MEM_IN); end
    tick();
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("[TB] FAIL rst_idle got=%b exp=1", REQ_READY); end
    checks++; if (wr_count !== 0) begin errors++; $display("[TB] FAIL rst_wrcount got=%0d exp=0", wr_count); end
    checks++; if (mem[8'h33] !== 32'hA500_0033) begin errors++; $display("[TB] FAIL rst_mem33 got=%h exp=a5000033", mem[8'h33]); end
  endtask

  task automatic test_single;
    int w0;
    w0 = wr_count;
    send_req(1'b1, 8'h10, 3'd0);
    checks++; if (WDATA_READY !== 1'b1) begin errors++; $display("[TB] FAIL sgl_wready got=%b exp=1", WDATA_READY); end
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("[TB] FAIL sgl_busy got=%b exp=0", REQ_READY); end
    checks++; if (MEM_WR !== 1'b0) begin errors++; $display("[TB] FAIL sgl_nowr got=%b exp=0", MEM_WR); end
    WDATA_VALID = 1'b1; WDATA = 32'hDEAD_BEEF;
    #1;
    checks++; if (MEM_WR !== 1'b1) begin errors++; $display("[TB] FAIL sgl_memwr got=%b exp=1", MEM_WR); end
    checks++; if (MEM_ADDR !== 32'h10) begin errors++; $display("[TB] FAIL sgl_addr got=%h exp=10", MEM_ADDR); end
    checks++; if (MEM_IN !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sgl_memin got=%h exp=deadbeef", MEM_IN); end
    tick();
    WDATA_VALID = 1'b0;
    checks++; if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL sgl_wdone got=%b exp=1", DONE); end
    checks++; if (mem[8'h10] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sgl_mem got=%h exp=deadbeef", mem[8'h10]); end
    checks++; if (wr_count !== w0 + 1) begin errors++; $display("[TB] FAIL sgl_wrcount got=%0d exp=%0d", wr_count, w0 + 1); end
    RDATA_READY = 1'b0;
    send_req(1'b0, 8'h10, 3'd0);
    checks++; if (RDATA_VALID !== 1'b0) begin errors++; $display("[TB] FAIL sgl_rv_early got=%b exp=0", RDATA_VALID); end
    tick();
    checks++; if (RDATA_VALID !== 1'b1) begin errors++; $display("[TB] FAIL sgl_rvalid got=%b exp=1", RDATA_VALID); end
    checks++; if (RDATA !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sgl_rdata got=%h exp=deadbeef", RDATA); end
    RDATA_READY = 1'b1;
    tick();
    RDATA_READY = 1'b0;
    checks++; if ({RDATA_VALID, DONE} !== 2'b01) begin errors++; $display("[TB] FAIL sgl_rdone got=%b exp=01", {RDATA_VALID, DONE}); end
  endtask

  task automatic test_wrap_burst;
    logic [31:0] exp_addr [4];
    exp_addr = '{32'hFE, 32'hFF, 32'h00, 32'h01};
    send_req(1'b1, 8'hFE, 3'd3);
    for (int i = 0; i < 4; i++) begin
      WDATA_VALID = 1'b1; WDATA = i + 1;
      #1;
      checks++; if (MEM_ADDR !== exp_addr[i]) begin errors++; $display("[TB] FAIL wrap_waddr%0d got=%h exp=%h", i, MEM_ADDR, exp_addr[i]); end
      tick();
    end
    WDATA_VALID = 1'b0;
    checks++; if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL wrap_wdone got=%b exp=1", DONE); end
    checks++; if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      errors++; $display("[TB] FAIL wrap_mem got=%h %h %h %h exp=1 2 3 4", mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
    RDATA_READY = 1'b1;
    send_req(1'b0, 8'hFE, 3'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (RDATA_VALID !== 1'b1 || RDATA !== 32'(i + 1)) begin errors++; $display("[TB] FAIL wrap_rbeat%0d got=%b/%h exp=1/%h", i, RDATA_VALID, RDATA, i + 1); end
      tick();
    end
    RDATA_READY = 1'b0;
    checks++; if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL wrap_rdone got=%b exp=1", DONE); end
  endtask

  task automatic test_backpressure;
    logic [4:0] pat;
    logic [31:0] wvals [3];
    int w0;
    int k;
    RDATA_READY = 1'b0;
    send_req(1'b0, 8'hFE, 3'd2);
    for (int b = 0; b < 3; b++) begin
      tick();
      for (int h = 0; h < 5; h++) begin
        checks++; if (RDATA_VALID !== 1'b1 || RDATA !== 32'(b + 1)) begin errors++; $display("[TB] FAIL bp_hold%0d_%0d got=%b/%h exp=1/%h", b, h, RDATA_VALID, RDATA, b + 1); end
        tick();
      end
      RDATA_READY = 1'b1;
      tick();
      RDATA_READY = 1'b0;
      checks++; if (RDATA_VALID !== 1'b0) begin errors++; $display("[TB] FAIL bp_taken%0d got=%b exp=0", b, RDATA_VALID); end
    end
    checks++; if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL bp_rdone got=%b exp=1", DONE); end
    pat = 5'b10110;
    wvals = '{32'h11, 32'h22, 32'h33};
    w0 = wr_count;
    k = 0;
    send_req(1'b1, 8'h40, 3'd2);
    for (int c = 0; c < 5; c++) begin
      WDATA_VALID = pat[c];
      WDATA = pat[c] ? wvals[k] : 32'hBAD0_0000;
      #1;
      checks++; if (MEM_WR !== pat[c]) begin errors++; $display("[TB] FAIL bp_memwr%0d got=%b exp=%b", c, MEM_WR, pat[c]); end
      if (pat[c]) k++;
      tick();
    end
    WDATA_VALID = 1'b0;
    checks++; if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL bp_wdone got=%b exp=1", DONE); end
    checks++; if (wr_count !== w0 + 3) begin errors++; $display("[TB] FAIL bp_wrcount got=%0d exp=%0d", wr_count, w0 + 3); end
    checks++; if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== {32'h11, 32'h22, 32'h33, 32'hA500_0043}) begin
      errors++; $display("[TB] FAIL bp_mem got=%h %h %h %h exp=11 22 33 a5000043", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
    end
  endtask

  task automatic test_reset_mid_burst;
    int w0;
    w0 = wr_count;
    send_req(1'b1, 8'h80, 3'd7);
    for (int i = 0; i < 2; i++) begin
      WDATA_VALID = 1'b1; WDATA = 32'hC0DE_0001 + i;
      tick();
    end
    RST = 1'b1; WDATA = 32'hDEAD_0000;
    #1;
    checks++; if (MEM_WR !== 1'b0) begin errors++; $display("[TB] FAIL mid_memwr got=%b exp=0", MEM_WR); end
    tick();
    RST = 1'b0; WDATA_VALID = 1'b0;
    checks++; if ({REQ_READY, DONE, WDATA_READY} !== 3'b100) begin errors++; $display("[TB] FAIL mid_idle got=%b exp=100", {REQ_READY, DONE, WDATA_READY}); end
    checks++; if (wr_count !== w0 + 2) begin errors++; $display("[TB] FAIL mid_wrcount got=%0d exp=%0d", wr_count, w0 + 2); end
    checks++; if ({mem[8'h80], mem[8'h81], mem[8'h82]} !== {32'hC0DE_0001, 32'hC0DE_0002, 32'hA500_0082}) begin
      errors++; $display("[TB] FAIL mid_mem got=%h %h %h exp=c0de0001 c0de0002 a5000082", mem[8'h80], mem[8'h81], mem[8'h82]);
    end
    tick();
    checks++; if ({REQ_READY, DONE} !== 2'b10) begin errors++; $display("[TB] FAIL mid_after got=%b exp=10", {REQ_READY, DONE}); end
  endtask

  task automatic test_back_to_back;
    send_req(1'b1, 8'h20, 3'd0);
    WDATA_VALID = 1'b1; WDATA = 32'h77;
    REQ_VALID = 1'b1; REQ_WR = 1'b0; REQ_ADDR = 8'h20; REQ_LEN = 3'd0;
    #1;
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy got=%b exp=0", REQ_READY); end
    tick();
    WDATA_VALID = 1'b0;
    checks++; if ({DONE, REQ_READY} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_donecycle got=%b exp=11", {DONE, REQ_READY}); end
    tick();
    REQ_WR = 1'b1; REQ_ADDR = 8'h50;
    checks++; if ({REQ_READY, DONE} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_accept got=%b exp=00", {REQ_READY, DONE}); end
    tick();
    checks++; if (RDATA_VALID !== 1'b1 || RDATA !== 32'h77) begin errors++; $display("[TB] FAIL b2b_rdata got=%b/%h exp=1/77", RDATA_VALID, RDATA); end
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rhold_busy got=%b exp=0", REQ_READY); end
    RDATA_READY = 1'b1;
    tick();
    RDATA_READY = 1'b0; REQ_VALID = 1'b0;
    checks++; if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rdone got=%b exp=1", DONE); end
    tick();
    checks++; if ({REQ_READY, WDATA_READY, MEM_ADDR} !== {2'b10, 32'h20}) begin
      errors++; $display("[TB] FAIL b2b_notqueued got=%b%b/%h exp=10/20", REQ_READY, WDATA_READY, MEM_ADDR);
    end
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_WR = 1'b0; REQ_ADDR = '0; REQ_LEN = '0;
    WDATA_VALID = 1'b0; WDATA = '0; RDATA_READY = 1'b0;
    test_reset();
    test_single();
    test_wrap_burst();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
